// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Two-requester scheduler in front of the SDRAM controller's
//            single-word request port. Port V (video line fetch) issues
//            read-only bursts with fixed priority; port C (CPU / loader)
//            issues single-word reads or writes. Words are serialised one
//            transaction at a time, burst addresses wrap within the row, and
//            read data is routed back to the owning requester.
// Options  : ARB_STARVE_GUARD_EN - when defined, a wait counter lets C win
//            an IDLE arbitration once it has waited MAX_WAIT cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbiter #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int MAX_WAIT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    // Video burst port
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic [DATA_W-1:0] v_rdata,
    output logic              v_rvalid,
    output logic              v_done,
    // CPU single-word port
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_done,
    // Controller request port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_V_ISSUE = 3'd1,
        S_V_WAIT  = 3'd2,
        S_V_END   = 3'd3,
        S_C_ISSUE = 3'd4,
        S_C_WAIT  = 3'd5,
        S_C_END   = 3'd6
    } state_t;

    // Burst index of the word currently in flight; BURST_LEN <= 256 fits 8 bits
    localparam logic [7:0] C_LAST = 8'(BURST_LEN - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_v_base;
    logic [7:0]        r_cnt;

    logic [7:0]        w_cnt_next;
    logic [7:0]        w_next_col;
    logic              w_c_first;

    assign w_cnt_next = r_cnt + 8'd1;
    // Column wraps modulo 256; bank and row bits stay those of the start address
    assign w_next_col = r_v_base[7:0] + w_cnt_next;

`ifdef ARB_STARVE_GUARD_EN
    localparam int               WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait;
    logic              w_c_grant;
    logic              w_c_owns;

    assign w_c_first = c_req && (r_wait == C_WAIT_MAX);
    assign w_c_grant = (r_state == S_IDLE) && c_req && (!v_req || w_c_first);
    assign w_c_owns  = (r_state == S_C_ISSUE) || (r_state == S_C_WAIT) ||
                       (r_state == S_C_END);

    // Count cycles C spends waiting for the bus; cleared on grant, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_c_grant) begin
            r_wait <= '0;
        end else if (c_req && !w_c_owns && (r_wait != C_WAIT_MAX)) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end
`else
    // Strict V priority: C only wins when V is not requesting
    assign w_c_first = 1'b0;
`endif

    // Main arbitration FSM with registered controller and requester outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_v_base  <= '0;
            r_cnt     <= '0;
            v_rdata   <= '0;
            v_rvalid  <= 1'b0;
            v_done    <= 1'b0;
            c_rdata   <= '0;
            c_done    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            v_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (v_req && !w_c_first) begin
                        r_v_base <= v_addr;
                        r_cnt    <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= v_addr;
                        r_state  <= S_V_ISSUE;
                    end else if (c_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= c_we;
                        mem_addr  <= c_addr;
                        mem_wdata <= c_wdata;
                        r_state   <= S_C_ISSUE;
                    end
                end
                S_V_ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= S_V_WAIT;
                    end
                end
                S_V_WAIT: begin
                    if (mem_rvalid) begin
                        v_rdata  <= mem_rdata;
                        v_rvalid <= 1'b1;
                        r_cnt    <= w_cnt_next;
                        if (r_cnt == C_LAST) begin
                            // done pulse lines up with the last data strobe
                            v_done  <= 1'b1;
                            r_state <= S_V_END;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {r_v_base[ADDR_W-1:8], w_next_col};
                            r_state  <= S_V_ISSUE;
                        end
                    end
                end
                S_V_END: begin
                    v_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_C_ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            c_done  <= 1'b1;
                            r_state <= S_C_END;
                        end else begin
                            r_state <= S_C_WAIT;
                        end
                    end
                end
                S_C_WAIT: begin
                    if (mem_rvalid) begin
                        c_rdata <= mem_rdata;
                        c_done  <= 1'b1;
                        r_state <= S_C_END;
                    end
                end
                S_C_END: begin
                    c_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Directed self-checking bench for sdram_arbiter with a simple
//            controller model (ack 1 cycle after request, rvalid 2 cycles
//            after ack, word memory with an address-derived fill pattern).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;

    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;
    localparam int MAX_WAIT  = 16;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              v_req = 1'b0;
    logic [ADDR_W-1:0] v_addr = '0;
    logic [DATA_W-1:0] v_rdata;
    logic              v_rvalid;
    logic              v_done;
    logic              c_req = 1'b0;
    logic              c_we = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0;
    logic [DATA_W-1:0] c_rdata;
    logic              c_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rvalid = 1'b0;
    logic              busy;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .v_req      (v_req),
        .v_addr     (v_addr),
        .v_rdata    (v_rdata),
        .v_rvalid   (v_rvalid),
        .v_done     (v_done),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_rdata    (c_rdata),
        .c_done     (c_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        int                cyc;
    } req_t;

    req_t              req_log[$];
    logic [DATA_W-1:0] vdata_log[$];
    int                cyc = 0;
    int                vdone_cnt = 0;
    int                vdone_cyc = 0;
    int                first_vdone_cyc = 0;
    int                vdone_bad = 0;
    int                cdone_cnt = 0;
    int                cdone_cyc = 0;

    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    int                rv_cnt = -1;
    logic [ADDR_W-1:0] rv_addr = '0;

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Controller model plus output monitor, evaluated away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (v_rvalid) vdata_log.push_back(v_rdata);
        if (v_done) begin
            if (vdone_cnt == 0) first_vdone_cyc = cyc;
            vdone_cnt = vdone_cnt + 1;
            vdone_cyc = cyc;
            if (!v_rvalid) vdone_bad = vdone_bad + 1;
        end
        if (c_done) begin
            cdone_cnt = cdone_cnt + 1;
            cdone_cyc = cyc;
        end
        mem_rvalid = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt = rv_cnt - 1;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_word(rv_addr);
                rv_cnt     = -1;
            end
        end
        mem_ack = 1'b0;
        if (mem_req) begin
            mem_ack = 1'b1;
            req_log.push_back('{mem_addr, mem_we, mem_wdata, cyc});
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin
                rv_cnt  = 2;
                rv_addr = mem_addr;
            end
        end
    end

    task automatic clear_logs();
        req_log.delete();
        vdata_log.delete();
        vdone_cnt = 0;
        vdone_bad = 0;
        cdone_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_req, mem_we, v_rvalid, v_done, c_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {busy, mem_req, mem_we, v_rvalid, v_done, c_done});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h required 0", mem_addr, mem_wdata);
        end
        checks++;
        if (v_rdata !== '0 || c_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got v %h c %h required 0", v_rdata, c_rdata);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got busy %b mem_req %b required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_v_burst(input logic [ADDR_W-1:0] a, input string nm);
        logic [ADDR_W-1:0] exp_a;
        int n;
        clear_logs();
        v_addr = a;
        v_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v_done && n < 200);
        checks++;
        if (v_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got v_done %b required 1", nm, v_done);
        end
        v_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_log.size() != BURST_LEN) begin
            errors++;
            $display("FAIL %s_nreq: got %0d required %0d", nm, req_log.size(), BURST_LEN);
        end
        for (int i = 0; i < BURST_LEN && i < req_log.size(); i++) begin
            exp_a = {a[ADDR_W-1:8], 8'(a[7:0] + i)};
            checks++;
            if (req_log[i].addr !== exp_a || req_log[i].we !== 1'b0) begin
                errors++;
                $display("FAIL %s_addr%0d: got %h we %b required %h we 0",
                         nm, i, req_log[i].addr, req_log[i].we, exp_a);
            end
        end
        checks++;
        if (vdata_log.size() != BURST_LEN) begin
            errors++;
            $display("FAIL %s_nrvalid: got %0d required %0d", nm, vdata_log.size(), BURST_LEN);
        end
        for (int i = 0; i < BURST_LEN && i < vdata_log.size(); i++) begin
            exp_a = {a[ADDR_W-1:8], 8'(a[7:0] + i)};
            checks++;
            if (vdata_log[i] !== rd_word(exp_a)) begin
                errors++;
                $display("FAIL %s_data%0d: got %h required %h", nm, i, vdata_log[i], rd_word(exp_a));
            end
        end
        checks++;
        if (vdone_cnt != 1 || vdone_bad != 0) begin
            errors++;
            $display("FAIL %s_vdone: got %0d pulses (%0d misaligned) required 1 (0)",
                     nm, vdone_cnt, vdone_bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after: got %b required 0", nm, busy);
        end
    endtask

    task automatic test_c_write_read();
        int n;
        clear_logs();
        c_we    = 1'b1;
        c_addr  = 22'h00010;
        c_wdata = 16'hBEEF;
        c_req   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_done && n < 50);
        c_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_log.size() != 1 || req_log[0].addr !== 22'h00010 ||
            req_log[0].we !== 1'b1 || req_log[0].wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL c_write_req: got %0d reqs first addr %h we %b wdata %h required 1 00010 1 beef",
                     req_log.size(), req_log[0].addr, req_log[0].we, req_log[0].wdata);
        end
        checks++;
        if (cdone_cnt != 1 || cdone_cyc != req_log[0].cyc + 1) begin
            errors++;
            $display("FAIL c_write_done: got %0d pulses at %0d required 1 at %0d",
                     cdone_cnt, cdone_cyc, req_log[0].cyc + 1);
        end
        clear_logs();
        c_we  = 1'b0;
        c_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_done && n < 50);
        checks++;
        if (c_done !== 1'b1 || c_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL c_read_data: got done %b rdata %h required 1 beef", c_done, c_rdata);
        end
        c_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_log.size() != 1 || req_log[0].we !== 1'b0 || cdone_cyc != req_log[0].cyc + 3) begin
            errors++;
            $display("FAIL c_read_txn: got %0d reqs we %b done at %0d required 1 0 at %0d",
                     req_log.size(), req_log[0].we, cdone_cyc, req_log[0].cyc + 3);
        end
        checks++;
        if (busy !== 1'b0 || cdone_cnt != 1) begin
            errors++;
            $display("FAIL c_read_end: got busy %b pulses %0d required 0 1", busy, cdone_cnt);
        end
    endtask

    task automatic test_both_same_cycle();
        int n;
        logic [DATA_W-1:0] got;
        clear_logs();
        v_addr = 22'h00200;
        c_we   = 1'b0;
        c_addr = 22'h00010;
        v_req  = 1'b1;
        c_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v_done && n < 200);
        v_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_done && n < 50);
        got   = c_rdata;
        c_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_log.size() != BURST_LEN + 1) begin
            errors++;
            $display("FAIL both_nreq: got %0d required %0d", req_log.size(), BURST_LEN + 1);
        end else begin
            checks++;
            if (req_log[0].addr !== 22'h00200 || req_log[BURST_LEN].addr !== 22'h00010) begin
                errors++;
                $display("FAIL both_order: got first %h last %h required 00200 00010",
                         req_log[0].addr, req_log[BURST_LEN].addr);
            end
            checks++;
            if (req_log[BURST_LEN].cyc != vdone_cyc + 2) begin
                errors++;
                $display("FAIL both_turnaround: got C req at %0d required %0d",
                         req_log[BURST_LEN].cyc, vdone_cyc + 2);
            end
        end
        checks++;
        if (got !== 16'hBEEF || cdone_cnt != 1 || vdone_cnt != 1) begin
            errors++;
            $display("FAIL both_result: got rdata %h cdone %0d vdone %0d required beef 1 1",
                     got, cdone_cnt, vdone_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int bad;
        clear_logs();
        v_addr = 22'h00400;
        v_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && !mem_req && req_log.size() > 0) && n < 50);
        checks++;
        if (!(busy === 1'b1 && mem_req === 1'b0)) begin
            errors++;
            $display("FAIL rstmid_reach_wait: got busy %b mem_req %b required 1 0", busy, mem_req);
        end
        rst   = 1'b1;
        v_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, mem_req, v_rvalid, v_done, c_done} !== 5'b0 || v_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b rdata %h required 00000 0000",
                     {busy, mem_req, v_rvalid, v_done, c_done}, v_rdata);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (v_rvalid || v_done || busy || mem_req) bad++;
        end
        checks++;
        if (bad != 0 || vdata_log.size() != 0 || vdone_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_dropped: got %0d active cycles %0d rvalid %0d done required 0 0 0",
                     bad, vdata_log.size(), vdone_cnt);
        end
    endtask

    task automatic test_starve_guard();
        int n;
        int c_hits;
        clear_logs();
        v_addr = 22'h00300;
        c_we   = 1'b0;
        c_addr = 22'h00010;
        v_req  = 1'b1;
        c_req  = 1'b1;
        repeat (120) begin
            @(negedge clk);
            if (c_done) c_req = 1'b0;
        end
        c_hits = 0;
        foreach (req_log[i]) if (req_log[i].addr === 22'h00010) c_hits++;
        checks++;
        if (c_hits != (GUARD ? 1 : 0) || cdone_cnt != (GUARD ? 1 : 0)) begin
            errors++;
            $display("FAIL starve_grant: got %0d C reqs %0d done required %0d",
                     c_hits, cdone_cnt, GUARD ? 1 : 0);
        end
        if (GUARD) begin
            checks++;
            if (req_log.size() < BURST_LEN + 1 || req_log[BURST_LEN].addr !== 22'h00010 ||
                req_log[BURST_LEN].cyc != first_vdone_cyc + 2) begin
                errors++;
                $display("FAIL starve_first_idle: got C req not at %0d (log size %0d)",
                         first_vdone_cyc + 2, req_log.size());
            end
        end
        v_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (c_done) c_req = 1'b0;
            n++;
        end while ((c_req || busy) && n < 300);
        checks++;
        if (busy !== 1'b0 || cdone_cnt != 1) begin
            errors++;
            $display("FAIL starve_release: got busy %b cdone %0d required 0 1", busy, cdone_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_v_burst(22'h000F0, "v_plain");
        test_v_burst(22'h123FC, "v_wrap");
        test_c_write_read();
        test_both_same_cycle();
        test_reset_mid_burst();
        test_starve_guard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
